// File: rtl/uart_alu_bridge_pkg.sv
// Shared types and constants for the UART-to-ALU bridge.
// Holds the opcode map, FSM state encoding and default byte width.
package uart_alu_bridge_pkg;

    localparam int DBIT_DEF = 8;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        CALC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

endpackage

// File: rtl/uart_alu_bridge_if.sv
// Byte-stream bus between the UART pair and the ALU bridge.
// master = UART side, slave = bridge side.
interface uart_alu_bridge_if
    import uart_alu_bridge_pkg::*;
#(
    parameter int DBIT = DBIT_DEF
) ();

    logic            s_tick;
    logic            rx_done_tick;
    logic [DBIT-1:0] rx_data;
    logic            tx_done_tick;
    logic            tx_start;
    logic [DBIT-1:0] tx_data;
    logic            busy;
    logic            op_err;
    logic            timeout;
    logic            overrun;

    modport master (
        output s_tick, rx_done_tick, rx_data, tx_done_tick,
        input  tx_start, tx_data, busy, op_err, timeout, overrun
    );

    modport slave (
        input  s_tick, rx_done_tick, rx_data, tx_done_tick,
        output tx_start, tx_data, busy, op_err, timeout, overrun
    );

endinterface

// File: rtl/uart_alu_bridge_alu.sv
// Combinational DBIT-wide ALU used by the bridge.
// Unknown opcodes yield zero and raise invalid.
module alu
    import uart_alu_bridge_pkg::*;
#(
    parameter int DBIT = DBIT_DEF
) (
    input  logic [DBIT-1:0] a,
    input  logic [DBIT-1:0] b,
    input  logic [5:0]      opcode,
    output logic [DBIT-1:0] result,
    output logic            invalid
);

    logic big_shift;

    assign big_shift = (32'(b) >= 32'(DBIT));

    // Decode the opcode into a wrapped DBIT-wide result.
    always_comb begin
        result  = '0;
        invalid = 1'b0;
        case (opcode)
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOR: result = ~(a | b);
            OP_SRL: result = big_shift ? '0 : (a >> b);
            OP_SRA: result = big_shift ? {DBIT{a[DBIT-1]}}
                                       : DBIT'($signed(a) >>> b);
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_alu_bridge.sv
// Collects A, B and opcode bytes from the UART receiver, computes
// the ALU result and hands it to the transmitter.
module uart_alu_bridge
    import uart_alu_bridge_pkg::*;
#(
    parameter int DBIT          = DBIT_DEF,
    parameter int TIMEOUT_TICKS = 2560
) (
    input  logic         clk,
    input  logic         reset,
    uart_alu_bridge_if.slave bus
);

    localparam logic [15:0] GAP_LAST = 16'(TIMEOUT_TICKS - 1);

    state_t          state;
    logic [DBIT-1:0] opa;
    logic [DBIT-1:0] opb;
    logic [5:0]      opcode;
    logic [15:0]     gap;
    logic [DBIT-1:0] tx_data_r;
    logic            tx_start_r;
    logic            timeout_r;
    logic            overrun_r;
    logic [DBIT-1:0] result;
    logic            invalid;
    logic            gap_expire;

    alu #(.DBIT(DBIT)) u_alu (
        .a      (opa),
        .b      (opb),
        .opcode (opcode),
        .result (result),
        .invalid(invalid)
    );

    // The tick that would make the gap count hit the limit ends the frame.
    assign gap_expire = bus.s_tick && (gap == GAP_LAST);

    // Frame sequencer; a byte arriving with the expiring tick still wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            opa        <= '0;
            opb        <= '0;
            opcode     <= '0;
            gap        <= '0;
            tx_data_r  <= '0;
            tx_start_r <= 1'b0;
            timeout_r  <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            tx_start_r <= 1'b0;
            timeout_r  <= 1'b0;
            overrun_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rx_done_tick) begin
                        opa   <= bus.rx_data;
                        gap   <= '0;
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (bus.rx_done_tick) begin
                        opb   <= bus.rx_data;
                        gap   <= '0;
                        state <= WAIT_OP;
                    end else if (gap_expire) begin
                        opa       <= '0;
                        gap       <= '0;
                        timeout_r <= 1'b1;
                        state     <= IDLE;
                    end else if (bus.s_tick) begin
                        gap <= gap + 16'd1;
                    end
                end
                WAIT_OP: begin
                    if (bus.rx_done_tick) begin
                        opcode <= bus.rx_data[5:0];
                        gap    <= '0;
                        state  <= CALC;
                    end else if (gap_expire) begin
                        opa       <= '0;
                        opb       <= '0;
                        gap       <= '0;
                        timeout_r <= 1'b1;
                        state     <= IDLE;
                    end else if (bus.s_tick) begin
                        gap <= gap + 16'd1;
                    end
                end
                CALC: begin
                    overrun_r  <= bus.rx_done_tick;
                    tx_data_r  <= result;
                    tx_start_r <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    overrun_r <= bus.rx_done_tick;
                    state     <= WAIT_TX;
                end
                WAIT_TX: begin
                    overrun_r <= bus.rx_done_tick;
                    if (bus.tx_done_tick) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_start = tx_start_r;
    assign bus.tx_data  = tx_data_r;
    assign bus.busy     = (state != IDLE);
    assign bus.op_err   = (state == CALC) && invalid;
    assign bus.timeout  = timeout_r;
    assign bus.overrun  = overrun_r;

endmodule

// File: doc/uart_alu_bridge.md
UART_ALU_BRIDGE -- requirements
Module: uart_alu_bridge

Interface
REQ-001 SHALL have parameter DBIT, default 8, giving the data byte width.
REQ-002 SHALL have parameter TIMEOUT_TICKS, default 2560, giving the maximum s_tick count allowed between operand bytes (1..65535).
REQ-003 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port s_tick  input  1  baud-oversample tick, the same one fed to the receiver.
REQ-006 SHALL have port rx_done_tick  input  1  one-cycle pulse: a received byte is valid on rx_data.
REQ-007 SHALL have port rx_data  input  DBIT  received byte.
REQ-008 SHALL have port tx_done_tick  input  1  one-cycle pulse: the transmitter has finished its byte.
REQ-009 SHALL have port tx_start  output  1  one-cycle pulse requesting transmission of tx_data.
REQ-010 SHALL have port tx_data  output  DBIT  ALU result byte, held stable from tx_start until tx_done_tick.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port op_err  output  1  one-cycle pulse: the opcode is unsupported.
REQ-013 SHALL have port timeout  output  1  one-cycle pulse: the frame was aborted by the inter-byte timeout.
REQ-014 SHALL have port overrun  output  1  one-cycle pulse: a byte arrived while the block could not accept it and was dropped.

Function
REQ-015 SHALL run a FSM with states IDLE, WAIT_B, WAIT_OP, CALC, SEND and WAIT_TX.
REQ-016 In IDLE, on rx_data valid (rx_done_tick), SHALL latch operand A and go to WAIT_B.
REQ-017 In WAIT_B, on rx_done_tick, SHALL latch operand B and go to WAIT_OP.
REQ-018 In WAIT_OP, on rx_done_tick, SHALL latch the opcode from rx_data[5:0] and go to CALC.
REQ-019 In CALC, SHALL register the ALU result into tx_data and go to SEND, one cycle after the opcode is latched.
REQ-020 In SEND, SHALL assert tx_start for exactly one cycle and go to WAIT_TX.
REQ-021 In WAIT_TX, on tx_done_tick, SHALL go to IDLE.
REQ-022 End-to-end latency: tx_start SHALL be high exactly 2 cycles after the rx_done_tick that carries the opcode.
REQ-023 SHALL support these opcodes:
  - ADD 6'b100000: A+B
  - SUB 6'b100010: A-B
  - AND 6'b100100
  - OR 6'b100101
  - XOR 6'b100110
  - NOR 6'b100111
  - SRA 6'b000011: A>>>B, arithmetic
  - SRL 6'b000010: A>>B, logical
REQ-024 Arithmetic SHALL be DBIT-wide, wrap modulo 2^DBIT, and discard carry and borrow.
REQ-025 Shift amount SHALL be B treated as unsigned; B>=DBIT SHALL give 0 for SRL and all sign bits for SRA.
REQ-026 An unsupported opcode SHALL give result 0, still be transmitted, and pulse op_err in the CALC cycle.
REQ-027 A 16-bit gap counter SHALL clear on every accepted byte and increment on s_tick in WAIT_B and WAIT_OP.
REQ-028 When the gap counter reaches TIMEOUT_TICKS, the block SHALL go to IDLE, discard the operands and pulse timeout.
REQ-029 If a timeout and rx_done_tick occur in the same cycle, the byte SHALL be accepted and the timeout suppressed.
REQ-030 rx_done_tick in CALC, SEND or WAIT_TX SHALL be dropped, pulse overrun, and leave the state unchanged.
REQ-031 tx_done_tick outside WAIT_TX SHALL be ignored.
REQ-032 tx_data SHALL change only in CALC.

Reset
REQ-033 Reset SHALL force state IDLE and clear A, B, opcode, the gap counter and tx_data to 0.
REQ-034 During and after reset, tx_start, op_err, timeout, overrun and busy SHALL all be 0.
REQ-035 Reset mid-frame SHALL abort the frame with no tx_start; the next byte SHALL be treated as operand A.

Structure
REQ-036 A shared package SHALL hold the opcode localparams, the state encoding and the default DBIT.
REQ-037 The combinational ALU SHALL be a sub-module named alu (inputs A, B, opcode; outputs result and invalid), reused by the ALU top.
REQ-038 All FSM outputs SHALL be registered or decoded from the state only, with no combinational path from rx_done_tick to tx_start.

Verification
REQ-039 SHALL cover: bytes 0x05, 0x03, 0x20 -> one tx_start 2 cycles after the third byte, tx_data=0x08.
REQ-040 SHALL cover: bytes 0x03, 0x05, 0x22 -> tx_data=0xFE; bytes 0x80, 0x02, 0x03 -> 0xE0; bytes 0x80, 0x02, 0x02 -> 0x20.
REQ-041 SHALL cover: opcode 0x3F -> op_err pulse, tx_data=0x00, transmitted.
REQ-042 SHALL cover: byte A then silence for TIMEOUT_TICKS s_ticks -> timeout pulse, busy=0, and the next three bytes form a correct new frame.
REQ-043 SHALL cover: rx_done_tick during WAIT_TX -> overrun pulse, tx_data unchanged, the frame completes normally.
REQ-044 SHALL cover: reset asserted in WAIT_OP -> all outputs 0, no tx_start, and the following frame 0x0F, 0xF0, 0x25 -> tx_data=0xFF.
